lcd_cmd_sequencer: RTL

- Memory-mapped LCD engine for the single-cycle core's I/O subsystem.
- Accepts byte-wide command or data writes from the LSU I/O path over a valid/ready handshake.
- Generates HD44780-style RS/RW/EN/DATA timing with cycle counters and runs an automatic power-on init sequence.
- Drives the 32-bit LCD word consumed by the board top in place of a raw software-toggled register.

---
 rtl/lcd_cmd_sequencer.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/lcd_cmd_sequencer.sv
// HD44780-style LCD write engine. Runs a power-on init sequence from a small ROM, then
// accepts byte-wide command/data writes over valid/ready and generates RS/RW/EN/DATA
// timing with a single shared down-counter.
module lcd_cmd_sequencer #(
  parameter int unsigned SETUP_CYC     = 4,
  parameter int unsigned PULSE_CYC     = 12,
  parameter int unsigned HOLD_CYC      = 4,
  parameter int unsigned DATA_WAIT_CYC = 2000,
  parameter int unsigned CMD_WAIT_CYC  = 2000,
  parameter int unsigned CLR_WAIT_CYC  = 82000,
  parameter int unsigned POWERUP_CYC   = 750000,
  parameter int unsigned CNT_W         = 20
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_vld,
  output logic        o_req_rdy,
  input  logic        i_req_rs,
  input  logic [7:0]  i_req_data,
  input  logic        i_lcd_on,
  output logic        o_init_done,
  output logic        o_busy,
  output logic [31:0] o_io_lcd
);

  typedef enum logic [2:0] {
    StPwrup,
    StInitLd,
    StSetup,
    StPulse,
    StHold,
    StWait,
    StIdle
  } state_e;

  // Counter load values: a timed state lasting N cycles is entered with N-1.
  localparam logic [CNT_W-1:0] SetupLd = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PulseLd = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HoldLd  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] DataLd  = CNT_W'(DATA_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] CmdLd   = CNT_W'(CMD_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] ClrLd   = CNT_W'(CLR_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] PwrupLd = CNT_W'(POWERUP_CYC - 1);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rs_q, rs_d;
  logic [7:0]       data_q, data_d;
  logic             en_q, en_d;
  logic             on_q;
  logic [1:0]       idx_q, idx_d;
  logic             done_q, done_d;
  logic             cnt_zero;

  // Init ROM: function set 8-bit/2-line, display on, clear, entry mode increment.
  function automatic logic [7:0] init_rom(input logic [1:0] idx);
    logic [7:0] val;
    unique case (idx)
      2'd0:    val = 8'h38;
      2'd1:    val = 8'h0C;
      2'd2:    val = 8'h01;
      default: val = 8'h06;
    endcase
    return val;
  endfunction

  // Clear/home commands (0x01..0x03) need the long execution wait.
  function automatic logic [CNT_W-1:0] wait_load(input logic rs, input logic [7:0] data);
    logic [CNT_W-1:0] ld;
    if (rs) begin
      ld = DataLd;
    end else if (data >= 8'h01 && data <= 8'h03) begin
      ld = ClrLd;
    end else begin
      ld = CmdLd;
    end
    return ld;
  endfunction

  assign cnt_zero = (cnt_q == '0);

  // Next-state, counter and pin-register logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rs_d    = rs_q;
    data_d  = data_q;
    idx_d   = idx_q;
    done_d  = done_q;

    case (state_q)
      StPwrup: begin
        if (cnt_zero) begin
          state_d = StInitLd;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StInitLd: begin
        rs_d    = 1'b0;
        data_d  = init_rom(idx_q);
        state_d = StSetup;
        cnt_d   = SetupLd;
      end
      StSetup: begin
        if (cnt_zero) begin
          state_d = StPulse;
          cnt_d   = PulseLd;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StPulse: begin
        if (cnt_zero) begin
          state_d = StHold;
          cnt_d   = HoldLd;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StHold: begin
        if (cnt_zero) begin
          state_d = StWait;
          cnt_d   = wait_load(rs_q, data_q);
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StWait: begin
        if (cnt_zero) begin
          if (!done_q) begin
            if (idx_q == 2'd3) begin
              done_d  = 1'b1;
              state_d = StIdle;
            end else begin
              idx_d   = idx_q + 2'd1;
              state_d = StInitLd;
            end
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StIdle: begin
        if (i_req_vld) begin
          rs_d    = i_req_rs;
          data_d  = i_req_data;
          state_d = StSetup;
          cnt_d   = SetupLd;
        end
      end
      default: begin
        state_d = StPwrup;
        cnt_d   = PwrupLd;
      end
    endcase

    // EN is registered from the next state so it is high exactly while in PULSE.
    en_d = (state_d == StPulse);
  end

  // State and pin registers; synchronous reset restarts the power-up delay.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= StPwrup;
      cnt_q   <= PwrupLd;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      en_q    <= 1'b0;
      on_q    <= 1'b0;
      idx_q   <= 2'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      en_q    <= en_d;
      on_q    <= i_lcd_on;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  assign o_req_rdy   = (state_q == StIdle);
  assign o_busy      = !o_req_rdy;
  assign o_init_done = done_q;
  // RW is tied low: the engine only ever writes.
  assign o_io_lcd    = {on_q, 20'd0, en_q, rs_q, 1'b0, data_q};

endmodule
